// File: rtl/clk_div_pkg.sv
// Shared defaults and types for the multi-channel clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int DEFAULT_DIV_DEF = 50_000_000;

  // Divisor / counter word at the default width.
  typedef logic [CNT_W_DEF-1:0] div_t;

  // Width of a channel index; a single channel still needs a 1-bit port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: counter, shadow/active divisor, tick pulse and square wave.
// Latency: tick/sq registered, high in the cycle after the terminal-count edge; divisor write effective at next TC or 1 edge on bypass.
// Backpressure: none; free-running, writes are always accepted.
module clk_div_ch #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             act_zero;
  logic [CNT_W-1:0] act_m1;
  logic             tc;

  assign act_zero = (act_q == '0);
  // Only meaningful when act_q != 0; tc is gated by act_zero so wrap at 0 is harmless.
  assign act_m1   = act_q - CNT_W'(1);
  assign tc       = en_i && !act_zero && (cnt_q == act_m1);

  // Next-state: sync beats everything, a zero divisor parks the channel, TC reloads from shadow.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = we_i ? val_i : shd_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (sync_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      act_d = we_i ? val_i : shd_q;
    end else if (act_zero) begin
      cnt_d = '0;
      if (we_i) begin
        act_d = val_i;
      end
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
      act_d  = we_i ? val_i : shd_q;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state register; reset drops counts and any pending shadow write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor updates and global sync.
// Latency: all outputs registered; wr_err one edge after a bad write; tick/sq per channel as in clk_div_ch.
// Backpressure: none; writes accepted every cycle, out-of-range channel writes dropped and flagged.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   CNT_W       = CNT_W_DEF,
  parameter div_t DEFAULT_DIV = div_t'(DEFAULT_DIV_DEF),
  parameter int   CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              div_we,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic              wr_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] RST_DIV = DEFAULT_DIV[CNT_W-1:0];

  logic              bad_ch;
  logic [NUM_CH-1:0] we_vec;
  logic              wr_err_q, wr_err_d;

  // A channel index only exists below NUM_CH; anything else is a software bug worth flagging.
  assign bad_ch   = (32'(div_ch) >= NUM_CH);
  assign wr_err_d = div_we && bad_ch;

  // One-hot write strobe to the addressed channel.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      we_vec[i] = div_we && (32'(div_ch) == i);
    end
  end

  // Bad-write flag, a single-cycle pulse per offending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .sync_i (sync),
      .we_i   (we_vec[g]),
      .val_i  (div_val),
      .tick_o (tick[g]),
      .sq_o   (sq[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus randomized traffic against a countdown reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       div_we = 1'b0;
  logic [2:0] div_ch = '0;
  logic [7:0] div_val = '0;
  logic       wr_err;
  logic [3:0] tick;
  logic [3:0] sq;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // Reference model: each channel is "active divisor, shadow divisor, edges left until the next tick".
  int         m_act [4];
  int         m_shd [4];
  int         m_left[4];
  logic [3:0] m_tick;
  logic [3:0] m_sq;
  logic       m_err;

  clk_div_multi #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEFAULT_DIV (32'd4),
    .CH_W        (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .div_we  (div_we),
    .div_ch  (div_ch),
    .div_val (div_val),
    .wr_err  (wr_err),
    .tick    (tick),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i]  = 4;
      m_shd[i]  = 4;
      m_left[i] = 4;
    end
    m_tick = '0;
    m_sq   = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic w,
                            input logic [2:0] ch, input logic [7:0] v);
    m_err = w && (ch >= 3'd4);
    for (int i = 0; i < 4; i++) begin
      bit hit;
      hit = w && (int'(ch) == i);
      if (hit) m_shd[i] = int'(v);
      if (s) begin
        m_act[i]  = m_shd[i];
        m_left[i] = m_act[i];
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
      end else if (m_act[i] == 0) begin
        m_tick[i] = 1'b0;
        if (hit) begin
          m_act[i]  = int'(v);
          m_left[i] = int'(v);
        end
      end else if (!e) begin
        m_tick[i] = 1'b0;
      end else if (m_left[i] == 1) begin
        m_tick[i] = 1'b1;
        m_sq[i]   = ~m_sq[i];
        m_act[i]  = m_shd[i];
        m_left[i] = m_act[i];
      end else begin
        m_tick[i] = 1'b0;
        m_left[i] = m_left[i] - 1;
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic cyc(input logic e, input logic s, input logic w,
                     input logic [2:0] ch, input logic [7:0] v);
    en = e; sync = s; div_we = w; div_ch = ch; div_val = v;
    @(posedge clk);
    model_step(e, s, w, ch, v);
    cyc_n++;
    #1;
    check("tick", tick, m_tick);
    check("sq", sq, m_sq);
    check("wr_err", wr_err, m_err);
  endtask

  initial begin
    logic sq2_frozen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick", tick, 0);
    check("rst_sq", sq, 0);
    check("rst_err", wr_err, 0);
    #3 rst_n = 1'b1;
    model_reset();
    cyc_n = 0;

    // Reset-and-run with a ch1=6 write landing mid-period
    for (int c = 1; c <= 16; c++) begin
      cyc(1'b1, 1'b0, (c == 2), 3'd1, 8'd6);
      check("run_tick0", tick[0], (c % 4) == 0);
      check("run_sq0", sq[0], ((c / 4) % 2) == 1);
      check("run_tick1", tick[1], (c == 4) || (c == 10) || (c == 16));
      check("run_tick3", tick[3], (c % 4) == 0);
    end

    // Disable ch2, then re-enable through the zero-divisor bypass
    cyc(1'b1, 1'b0, 1'b1, 3'd2, 8'd0);
    sq2_frozen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      if (k == 5) sq2_frozen = sq[2];
      if (k >= 5) begin
        check("off_tick2", tick[2], 0);
        check("off_sq2", sq[2], sq2_frozen);
      end
    end
    cyc(1'b1, 1'b0, 1'b1, 3'd2, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check("byp_tick2", tick[2], k == 3);
    end

    // Count enable held low, then sync together with a ch0=2 write
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      check("hold_tick", tick, 0);
    end
    cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'd2);
    check("sync_sq", sq, 0);
    check("sync_tick", tick, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check("sync_tick0", tick[0], (k % 2) == 0);
      check("sync_tick3", tick[3], k == 4);
    end

    // Out-of-range channel write
    cyc(1'b1, 1'b0, 1'b1, 3'd5, 8'd9);
    check("err_pulse", wr_err, 1);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    check("err_clear", wr_err, 0);

    // Divisor of one keeps tick high
    cyc(1'b1, 1'b0, 1'b1, 3'd3, 8'd1);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check("d1_tick3", tick[3], 1);
    end

    // Asynchronous reset mid-period
    #2 rst_n = 1'b0;
    en = 1'b0; div_we = 1'b0; sync = 1'b0;
    #1;
    check("arst_tick", tick, 0);
    check("arst_sq", sq, 0);
    check("arst_err", wr_err, 0);
    #1 rst_n = 1'b1;
    model_reset();
    cyc_n = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      check("arst_div", tick, ((c % 4) == 0) ? 4'hF : 4'h0);
    end

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 9) != 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0,
          3'($urandom_range(0, 5)),
          8'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
